// File: rtl/pp_column_sequencer.sv
// pp_column_sequencer
//   Column-serial feeder/collector for an external 8:2 compressor in an 8x8
//   multiplier. Latches one operand pair, presents the 15 partial-product
//   columns one per cycle, and accumulates the compressor's 2-bit result,
//   weighted by the column position, into a 17-bit product.
//
// Parameters
//   TRUNC_COLS  number of LSB columns skipped (col_vec forced to zero and
//               col_res ignored); 15 or more yields a zero product.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     operand handshake (a, b)
//   col_vec/col_idx       current column bits / index to the compressor
//   col_valid             column outputs meaningful this cycle
//   col_res               compressor result for col_vec (weights 1 and 2)
//   out_valid/out_ready   product handshake
//   prod, ovf             acc[15:0], acc[16]
module pp_column_sequencer #(
  parameter int unsigned TRUNC_COLS = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] col_vec,
  output logic [3:0] col_idx,
  output logic       col_valid,
  input  logic [1:0] col_res,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [15:0] prod,
  output logic       ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nx;
  logic [7:0]  a_r, b_r;
  logic [16:0] acc;
  logic [3:0]  c;
  logic        col_live;
  logic [16:0] col_term;

  // Truncated columns neither drive the compressor nor contribute to acc.
  assign col_live = (32'(c) >= TRUNC_COLS);
  assign col_term = 17'(col_res) << c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      acc   <= '0;
      c     <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r <= a;
            b_r <= b;
            acc <= '0;
            c   <= '0;
          end
        end
        RUN: begin
          if (col_live) acc <= acc + col_term;
          c <= c + 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    col_valid = 1'b0;
    col_idx   = '0;
    col_vec   = '0;
    out_valid = 1'b0;
    prod      = '0;
    ovf       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        col_valid = 1'b1;
        col_idx   = c;
        if (col_live) begin
          // Bit k pairs a[k] with b[c-k]; only 0 <= c-k <= 7 exists.
          for (int unsigned k = 0; k < 8; k++) begin
            if (({1'b0, c} >= 5'(k)) && (({1'b0, c} - 5'(k)) <= 5'd7))
              col_vec[3'(k)] = a_r[3'(k)] & b_r[3'(c - 4'(k))];
          end
        end
        if (c == 4'd14) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        prod      = acc[15:0];
        ovf       = acc[16];
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: doc/pp_column_sequencer.md
Name: pp_column_sequencer

Overview:
- Upstream feeder and result collector for the 8:2 compressor (exact or approximate variant) in the column-serial 8x8 multiplier used by the image-processing datapath.
- Accepts one operand pair, forms the 8x8 AND partial-product matrix, and presents one 8-bit column vector per cycle to the compressor.
- Accumulates the compressor's 2-bit result, weighted by column position, into the product.
- The compressor is instantiated outside this block and is purely combinational between col_vec and col_res.

Parameters:
- TRUNC_COLS, 0, number of LSB columns (0..14) skipped: their col_vec is forced to 8'h00 and their col_res is ignored (truncation approximation).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- a  in  8  multiplicand.
- b  in  8  multiplier.
- col_vec  out  8  current column bits to the compressor; bit k = a[k] & b[c-k] for valid k, else 0.
- col_idx  out  4  current column index c (0..14).
- col_valid  out  1  col_vec/col_idx meaningful this cycle.
- col_res  in  2  compressor output for the current col_vec; [0] weight 1, [1] weight 2.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- prod  out  16  accumulated product, acc[15:0].
- ovf  out  1  acc[16]; set when the approximate sum exceeds 16 bits.

Behaviour:
- Reset (sync, rst=1 at a clock edge):
  - state=IDLE; in_ready=1; col_valid=0; out_valid=0; col_vec=0; col_idx=0; prod=0; ovf=0; accumulator cleared.
  - Reset mid-RUN or mid-DONE aborts the operation; the in-flight product is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch a and b, clear the 17-bit accumulator, set c=0, go to RUN.
- RUN:
  - in_ready=0; col_valid=1; col_idx=c.
  - col_vec[k] = a_r[k] & b_r[c-k] for max(0,c-7) <= k <= min(7,c); all other bits are 0. Bit positions 8..k unused by the column count are 0.
  - col_res is sampled at the same clock edge.
  - If c >= TRUNC_COLS: acc <= acc + ({col_res[1],col_res[0]} << c). Otherwise acc is unchanged.
  - Accumulate in 17-bit unsigned arithmetic. The maximum reachable value is 3*(2^15-1)=98301, so there is no wrap.
  - c increments each cycle. After column 14 is consumed, go to DONE.
- DONE:
  - out_valid=1; prod=acc[15:0]; ovf=acc[16]; col_valid=0; col_vec=0.
  - prod and ovf are held stable while out_valid=1 and out_ready=0.
  - On out_ready: out_valid<=0, go to IDLE.
  - in_ready stays 0 in DONE. There is no overlap between operations.
- Latency:
  - Operand accept at edge T.
  - Columns presented in cycles T+1..T+15.
  - out_valid asserted from T+16.
  - Back-to-back throughput is 1 product per 17 cycles when out_ready is held at 1.
- Inputs a, b and in_valid are ignored outside IDLE.
- The block does not check col_res for consistency. Compressor error passes straight into prod.
- TRUNC_COLS >= 15 yields prod=0 and ovf=0. TRUNC_COLS=0 means full accumulation.

Test Plan:
1. Reset; a=8'h01, b=8'h01; bench compressor = popcount mod 4 -> col_vec=8'h01 at col_idx=0, 8'h00 elsewhere; out_valid at T+16; prod=16'h0001, ovf=0.
2. a=8'h03, b=8'h03; ideal compressor -> column vectors c0=8'h01, c1=8'h03, c2=8'h02; prod=16'd9.
3. a=8'hFF, b=8'h01 -> col c has only bit c set for c=0..7, zero for 8..14; prod=16'd255.
4. Bench forces col_res=2'b11 every column; TRUNC_COLS=0 -> acc=98301; prod=16'h7FFD, ovf=1.
5. TRUNC_COLS=2, a=8'h03, b=8'h03 -> col_vec=0 at c0..c1, c0..c1 results ignored; prod=16'd4.
6. Hold out_ready=0 for 5 cycles in DONE -> prod stable and in_ready=0 throughout. Assert rst during RUN at c=6 -> next cycle state IDLE, in_ready=1, col_valid=0, out_valid=0, prod=0.
